// File: rtl/lsu_if.sv
// Split read/write memory bus between the LSU (master) and memory (slave).
// Address channels AR/AW, data channels R/W and write response B, all valid/ready.
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              bus_ar_valid;
  logic              bus_ar_ready;
  logic [ADDR_W-1:0] bus_ar_addr;
  logic              bus_r_valid;
  logic              bus_r_ready;
  logic [DATA_W-1:0] bus_r_data;
  logic [1:0]        bus_r_resp;
  logic              bus_aw_valid;
  logic              bus_aw_ready;
  logic [ADDR_W-1:0] bus_aw_addr;
  logic              bus_w_valid;
  logic              bus_w_ready;
  logic [DATA_W-1:0] bus_w_data;
  logic [7:0]        bus_w_strb;
  logic              bus_b_valid;
  logic              bus_b_ready;
  logic [1:0]        bus_b_resp;

  modport master (
    output bus_ar_valid, bus_ar_addr, bus_r_ready,
           bus_aw_valid, bus_aw_addr, bus_w_valid, bus_w_data, bus_w_strb, bus_b_ready,
    input  bus_ar_ready, bus_r_valid, bus_r_data, bus_r_resp,
           bus_aw_ready, bus_w_ready, bus_b_valid, bus_b_resp
  );
  modport slave (
    input  bus_ar_valid, bus_ar_addr, bus_r_ready,
           bus_aw_valid, bus_aw_addr, bus_w_valid, bus_w_data, bus_w_strb, bus_b_ready,
    output bus_ar_ready, bus_r_valid, bus_r_data, bus_r_resp,
           bus_aw_ready, bus_w_ready, bus_b_valid, bus_b_resp
  );
endinterface

// File: rtl/lsu.sv
// MEM-stage load/store unit: one request at a time on a split read/write bus.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses complete with lsu_err and no bus traffic.
module lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_w_data,
  output logic              idle,
  output logic              lsu_r_ready,
  output logic              lsu_w_valid,
  output logic              lsu_r_valid,
  output logic              lsu_w_ready,
  output logic [DATA_W-1:0] lsu_r_data,
  output logic              lsu_err,
  lsu_if.master             bus
);
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [DATA_W-1:0] w_data_q, w_data_d, r_data_q, r_data_d;
  logic [7:0]        w_strb_q, w_strb_d;
  logic ar_valid_q, ar_valid_d, r_ready_q, r_ready_d;
  logic aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, b_ready_q, b_ready_d;
  logic idle_q, idle_d, rd_out_q, rd_out_d, wr_out_q, wr_out_d;
  logic r_pulse_q, r_pulse_d, w_pulse_q, w_pulse_d, err_q, err_d;

  logic              trap;
  logic [7:0]        strb_base;
  logic [DATA_W-1:0] r_shift, r_ext;

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    case (in_funct3[1:0])
      2'd0:    trap = 1'b0;
      2'd1:    trap = in_addr[0];
      2'd2:    trap = |in_addr[1:0];
      default: trap = |in_addr[2:0];
    endcase
  end
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    case (in_funct3[1:0])
      2'd0:    strb_base = 8'h01;
      2'd1:    strb_base = 8'h03;
      2'd2:    strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  end

  // Lane-crossing loads simply lose the bytes shifted out of the 64-bit word.
  assign r_shift = bus.bus_r_data >> {addr_q[2:0], 3'b000};
  always_comb begin
    case (funct3_q)
      3'b000:  r_ext = {{56{r_shift[7]}},  r_shift[7:0]};
      3'b001:  r_ext = {{48{r_shift[15]}}, r_shift[15:0]};
      3'b010:  r_ext = {{32{r_shift[31]}}, r_shift[31:0]};
      3'b100:  r_ext = {56'd0, r_shift[7:0]};
      3'b101:  r_ext = {48'd0, r_shift[15:0]};
      3'b110:  r_ext = {32'd0, r_shift[31:0]};
      default: r_ext = r_shift;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    r_data_d   = r_data_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    idle_d     = idle_q;
    rd_out_d   = rd_out_q;
    wr_out_d   = wr_out_q;
    err_d      = err_q;
    r_pulse_d  = 1'b0;
    w_pulse_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && (in_load || in_store)) begin
          addr_d   = in_addr;
          funct3_d = in_funct3;
          w_data_d = in_w_data << {in_addr[2:0], 3'b000};
          w_strb_d = strb_base << in_addr[2:0];
          idle_d   = 1'b0;
          rd_out_d = in_load;
          wr_out_d = !in_load;
          if (trap) begin
            state_d   = S_DONE;
            err_d     = 1'b1;
            r_pulse_d = in_load;
            w_pulse_d = !in_load;
            if (in_load) r_data_d = '0;
          end else if (in_load) begin
            state_d    = S_AR;
            ar_valid_d = 1'b1;
          end else begin
            state_d    = S_AWW;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
          end
        end
      end
      S_AR: if (bus.bus_ar_ready) begin
        ar_valid_d = 1'b0;
        r_ready_d  = 1'b1;
        state_d    = S_R;
      end
      S_R: if (bus.bus_r_valid) begin
        r_ready_d = 1'b0;
        r_data_d  = r_ext;
        err_d     = bus.bus_r_resp != 2'd0;
        r_pulse_d = 1'b1;
        state_d   = S_DONE;
      end
      S_AWW: begin
        // AW and W retire independently; leave once neither is still pending.
        aw_valid_d = aw_valid_q && !bus.bus_aw_ready;
        w_valid_d  = w_valid_q && !bus.bus_w_ready;
        if (!aw_valid_d && !w_valid_d) begin
          b_ready_d = 1'b1;
          state_d   = S_B;
        end
      end
      S_B: if (bus.bus_b_valid) begin
        b_ready_d = 1'b0;
        err_d     = bus.bus_b_resp != 2'd0;
        w_pulse_d = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        idle_d   = 1'b1;
        rd_out_d = 1'b0;
        wr_out_d = 1'b0;
        err_d    = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      funct3_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      r_data_q   <= '0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      idle_q     <= 1'b1;
      rd_out_q   <= 1'b0;
      wr_out_q   <= 1'b0;
      r_pulse_q  <= 1'b0;
      w_pulse_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      r_data_q   <= r_data_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      idle_q     <= idle_d;
      rd_out_q   <= rd_out_d;
      wr_out_q   <= wr_out_d;
      r_pulse_q  <= r_pulse_d;
      w_pulse_q  <= w_pulse_d;
      err_q      <= err_d;
    end
  end

  assign idle             = idle_q;
  assign lsu_r_ready      = rd_out_q;
  assign lsu_w_valid      = wr_out_q;
  assign lsu_r_valid      = r_pulse_q;
  assign lsu_w_ready      = w_pulse_q;
  assign lsu_r_data       = r_data_q;
  assign lsu_err          = err_q;
  assign bus.bus_ar_valid = ar_valid_q;
  assign bus.bus_ar_addr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign bus.bus_r_ready  = r_ready_q;
  assign bus.bus_aw_valid = aw_valid_q;
  assign bus.bus_aw_addr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign bus.bus_w_valid  = w_valid_q;
  assign bus.bus_w_data   = w_data_q;
  assign bus.bus_w_strb   = w_strb_q;
  assign bus.bus_b_ready  = b_ready_q;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, bus error, misalignment, reset and busy cases.
// Build with LSU_MISALIGN_TRAP_EN defined to exercise the trap path.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_load, in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [63:0] in_w_data;
  logic        idle, lsu_r_ready, lsu_w_valid, lsu_r_valid, lsu_w_ready, lsu_err;
  logic [63:0] lsu_r_data;
  int total = 0;
  int bad   = 0;

  lsu_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  lsu #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_w_data(in_w_data),
    .idle(idle), .lsu_r_ready(lsu_r_ready), .lsu_w_valid(lsu_w_valid),
    .lsu_r_valid(lsu_r_valid), .lsu_w_ready(lsu_w_ready), .lsu_r_data(lsu_r_data),
    .lsu_err(lsu_err), .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Outputs are registered, so 1 time unit after the edge is a stable sample point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic ld, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [63:0] wd);
    in_valid = 1'b1; in_load = ld; in_store = st;
    in_funct3 = f3; in_addr = a; in_w_data = wd;
  endtask

  task automatic bus_in(input logic arr, input logic rv, input logic [63:0] rd, input logic [1:0] rr,
                        input logic awr, input logic wr, input logic bv, input logic [1:0] br);
    bus.bus_ar_ready = arr; bus.bus_r_valid = rv; bus.bus_r_data = rd; bus.bus_r_resp = rr;
    bus.bus_aw_ready = awr; bus.bus_w_ready = wr; bus.bus_b_valid = bv; bus.bus_b_resp = br;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
    in_funct3 = 3'd0; in_addr = '0; in_w_data = '0;
    bus_in(0, 0, 64'd0, 2'd0, 0, 0, 0, 2'd0);
    tick(); tick();
    chk("rst_idle", {63'd0, idle}, 64'd1);
    chk("rst_valids", {58'd0, bus.bus_ar_valid, bus.bus_aw_valid, bus.bus_w_valid,
                       lsu_r_valid, lsu_w_ready, lsu_err}, 64'd0);
    chk("rst_rdata", lsu_r_data, 64'd0);
    rst = 1'b1;
    tick();

    // lb with sign extension, minimum latency
    bus_in(1, 1, 64'h00000000_80000000, 2'd0, 0, 0, 0, 2'd0);
    req(1, 0, 3'b000, 32'h80000003, 64'd0);
    tick();
    in_valid = 1'b0;
    chk("lb_c1_idle", {63'd0, idle}, 64'd0);
    chk("lb_c1_arv", {63'd0, bus.bus_ar_valid}, 64'd1);
    chk("lb_c1_araddr", {32'd0, bus.bus_ar_addr}, 64'h80000000);
    chk("lb_c1_rrdy_out", {63'd0, lsu_r_ready}, 64'd1);
    tick();
    chk("lb_c2_rready", {62'd0, bus.bus_r_ready, bus.bus_ar_valid}, 64'd2);
    tick();
    chk("lb_c3_rvalid", {62'd0, lsu_r_valid, lsu_err}, 64'd2);
    chk("lb_c3_data", lsu_r_data, 64'hFFFFFFFF_FFFFFF80);
    tick();
    chk("lb_c4_end", {62'd0, lsu_r_valid, idle}, 64'd1);

    // sh with AW delayed three cycles, W immediate
    bus_in(0, 0, 64'd0, 2'd0, 0, 1, 0, 2'd0);
    req(0, 1, 3'b001, 32'h80000006, 64'h0000_0000_0000_BEEF);
    tick();
    in_valid = 1'b0;
    chk("sh_strb", {56'd0, bus.bus_w_strb}, 64'hC0);
    chk("sh_wdata", bus.bus_w_data, 64'hBEEF0000_00000000);
    chk("sh_awaddr", {32'd0, bus.bus_aw_addr}, 64'h80000000);
    chk("sh_c1_valids", {61'd0, bus.bus_aw_valid, bus.bus_w_valid, lsu_w_valid}, 64'd7);
    tick();
    chk("sh_c2_valids", {62'd0, bus.bus_aw_valid, bus.bus_w_valid}, 64'd2);
    chk("sh_rdata_hold", lsu_r_data, 64'hFFFFFFFF_FFFFFF80);
    tick();
    chk("sh_c3_valids", {61'd0, bus.bus_aw_valid, bus.bus_w_valid, bus.bus_b_ready}, 64'd4);
    tick();
    bus.bus_aw_ready = 1'b1;
    tick();
    bus.bus_aw_ready = 1'b0;
    chk("sh_c5_bready", {62'd0, bus.bus_b_ready, bus.bus_aw_valid}, 64'd2);
    chk("sh_c5_nopulse", {63'd0, lsu_w_ready}, 64'd0);
    bus.bus_b_valid = 1'b1;
    tick();
    bus.bus_b_valid = 1'b0;
    chk("sh_c6_wready", {62'd0, lsu_w_ready, lsu_err}, 64'd2);
    tick();
    chk("sh_c7_end", {61'd0, lsu_w_ready, lsu_w_valid, idle}, 64'd1);

    // lwu with error response
    bus_in(1, 1, 64'hFFFFFFFF_00000000, 2'd2, 0, 0, 0, 2'd0);
    req(1, 0, 3'b110, 32'h80000004, 64'd0);
    tick(); in_valid = 1'b0;
    tick(); tick();
    chk("lwu_err", {62'd0, lsu_r_valid, lsu_err}, 64'd3);
    chk("lwu_data", lsu_r_data, 64'h00000000_FFFFFFFF);
    tick();
    chk("lwu_err_clr", {63'd0, lsu_err}, 64'd0);

    // misaligned lw
    bus_in(1, 1, 64'h00008765_43210000, 2'd0, 0, 0, 0, 2'd0);
    req(1, 0, 3'b010, 32'h80000002, 64'd0);
    tick(); in_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_trap_noar", {63'd0, bus.bus_ar_valid}, 64'd0);
    chk("mis_trap_pulse", {62'd0, lsu_r_valid, lsu_err}, 64'd3);
    chk("mis_trap_data", lsu_r_data, 64'd0);
    tick();
    chk("mis_trap_idle", {62'd0, idle, bus.bus_ar_valid}, 64'd2);
`else
    chk("mis_ar", {31'd0, bus.bus_ar_valid, bus.bus_ar_addr}, 64'h1_80000000);
    tick(); tick();
    chk("mis_pulse", {62'd0, lsu_r_valid, lsu_err}, 64'd2);
    chk("mis_data", lsu_r_data, 64'hFFFFFFFF_87654321);
    tick();
`endif

    // reset while waiting in R
    bus_in(1, 0, 64'd0, 2'd0, 0, 0, 0, 2'd0);
    req(1, 0, 3'b011, 32'h80000008, 64'd0);
    tick(); in_valid = 1'b0;
    tick();
    chk("rstmid_in_r", {63'd0, bus.bus_r_ready}, 64'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rstmid_idle", {63'd0, idle}, 64'd1);
    chk("rstmid_valids", {58'd0, bus.bus_ar_valid, bus.bus_r_ready, lsu_r_ready,
                          lsu_r_valid, lsu_w_ready, lsu_err}, 64'd0);
    bus.bus_r_valid = 1'b1;
    tick();
    chk("rstmid_nopulse", {62'd0, lsu_r_valid, idle}, 64'd1);
    bus_in(1, 1, 64'h01234567_89ABCDEF, 2'd0, 0, 0, 0, 2'd0);
    req(1, 0, 3'b011, 32'h80000010, 64'd0);
    tick(); in_valid = 1'b0;
    tick(); tick();
    chk("ld_after_rst", lsu_r_data, 64'h01234567_89ABCDEF);
    chk("ld_after_rst_v", {62'd0, lsu_r_valid, lsu_err}, 64'd2);
    tick();

    // valid without load/store does nothing
    req(0, 0, 3'b011, 32'h80000018, 64'd0);
    tick(); in_valid = 1'b0;
    chk("noop_idle", {60'd0, idle, bus.bus_ar_valid, bus.bus_aw_valid, lsu_w_valid}, 64'd8);

    // sd, with a second request held while busy
    bus_in(0, 0, 64'd0, 2'd0, 1, 1, 0, 2'd0);
    req(0, 1, 3'b011, 32'h80000020, 64'h11223344_55667788);
    tick();
    req(1, 0, 3'b000, 32'h80000040, 64'd0);
    chk("sd_strb", {56'd0, bus.bus_w_strb}, 64'hFF);
    chk("sd_wdata", bus.bus_w_data, 64'h11223344_55667788);
    tick();
    chk("sd_c2_b", {61'd0, bus.bus_b_ready, bus.bus_aw_valid, bus.bus_w_valid}, 64'd4);
    chk("busy_noar_c2", {62'd0, bus.bus_ar_valid, idle}, 64'd0);
    tick();
    bus.bus_b_valid = 1'b1;
    chk("busy_noar_c3", {62'd0, bus.bus_ar_valid, idle}, 64'd0);
    tick();
    bus.bus_b_valid = 1'b0;
    in_valid = 1'b0;
    chk("sd_done", {61'd0, lsu_w_ready, bus.bus_ar_valid, lsu_r_ready}, 64'd4);
    tick();
    chk("busy_ignored", {61'd0, idle, bus.bus_ar_valid, lsu_r_ready}, 64'd4);

    // load and store both high is a load (lbu)
    bus_in(1, 1, 64'h00000000_0000F000, 2'd0, 0, 0, 0, 2'd0);
    req(1, 1, 3'b100, 32'h80000001, 64'd0);
    tick(); in_valid = 1'b0;
    chk("both_is_load", {62'd0, bus.bus_ar_valid, bus.bus_aw_valid}, 64'd2);
    tick(); tick();
    chk("lbu_data", lsu_r_data, 64'h00000000_000000F0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit of the MEM stage. Accepts one memory request at a time from the EX/MEM pipeline register and runs it on a split read/write memory bus with valid/ready channels. Returns aligned, sign- or zero-extended load data and completion pulses to the MEM/WB register. Its `idle`/`lsu_*` handshake outputs drive that register's `mem_idle` and `mem_lsu_*` inputs.

## Interface
- `ADDR_W`, 32: request/bus address width
- `DATA_W`, 64: data width; fixed at 64, 8 byte lanes

- `clk` in 1: sole clock; all state updates on rising edge
- `rst` in 1: reset, synchronous, active-low
- `in_valid` in 1: request valid; counts only when `in_load|in_store`
- `in_load` / `in_store` in 1: access type; both high means load
- `in_funct3` in 3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
- `in_addr` in 32: byte address
- `in_w_data` in 64: store data, LSB-justified
- `idle` out 1: no request outstanding; request accepted when `in_valid&&idle`
- `lsu_r_ready` out 1: high while a load is outstanding
- `lsu_w_valid` out 1: high while a store is outstanding
- `lsu_r_valid` out 1: one-cycle pulse, load complete
- `lsu_w_ready` out 1: one-cycle pulse, store complete
- `lsu_r_data` out 64: extended load data; holds until next load completes
- `lsu_err` out 1: high with a completion pulse when the bus response ≠ 0 or a misalignment trap occurs
- `bus_ar_valid` out 1, `bus_ar_ready` in 1, `bus_ar_addr` out 32
- `bus_r_valid` in 1, `bus_r_ready` out 1, `bus_r_data` in 64, `bus_r_resp` in 2
- `bus_aw_valid` out 1, `bus_aw_ready` in 1, `bus_aw_addr` out 32
- `bus_w_valid` out 1, `bus_w_ready` in 1, `bus_w_data` out 64, `bus_w_strb` out 8
- `bus_b_valid` in 1, `bus_b_ready` out 1, `bus_b_resp` in 2

## Operation
- **Acceptance.** On acceptance, latch `addr`, `funct3`, type and store data. `idle` goes low on the next cycle.
- **FSM states:** IDLE, AR, R, AWW, B, DONE.
  - IDLE: load → AR; store → AWW; misaligned with trap → DONE (see Configuration).
  - AR: `bus_ar_valid=1`. On `bus_ar_ready` → R.
  - R: `bus_r_ready=1`. On `bus_r_valid`, register extended data and resp → DONE.
  - AWW: `bus_aw_valid` and `bus_w_valid` are tracked independently. Each drops after its own handshake. When both are done → B. Same-cycle handshakes are allowed.
  - B: `bus_b_ready=1`. On `bus_b_valid`, register resp → DONE.
  - DONE: pulse `lsu_r_valid` or `lsu_w_ready` (with `lsu_err`) → IDLE.
- **Outstanding flags.** `lsu_r_ready` is high in AR/R/DONE for a load. `lsu_w_valid` is high in AWW/B/DONE for a store.
- **Bus addresses.** `bus_ar_addr` and `bus_aw_addr` = latched addr with `[2:0]` cleared.
- **Load data.**
  - Extract `bus_r_data >> (addr[2:0]*8)`.
  - Sign-extend for b/h/w. Zero-extend for bu/hu/wu. d is passed through.
- **Store data and strobes.**
  - `bus_w_data = in_w_data << (addr[2:0]*8)`.
  - `bus_w_strb = {0x01, 0x03, 0x0F, 0xFF}[size] << addr[2:0]`, truncated to 8 bits.
- **funct3 111** is treated as d.
- **Reset.** `rst` low in any state → IDLE. Any bus transaction in flight is abandoned. All outputs reset to 0, except `idle`, which resets to 1.

## Timing
- **Minimum load latency:** accept at cycle 0; AR at cycle 1 (ready same cycle); R at cycle 2; `lsu_r_valid` at cycle 3.
- **Minimum store latency:** accept at 0; AW+W at 1; B at 2; `lsu_w_ready` at 3.
- **Misaligned trap:** completion pulse at cycle 1.
- **Bus protocol:** valids are registered and never drop before their ready. No combinational path from bus inputs to bus valid outputs.
- **Back-to-back:** `idle` returns at the cycle after DONE, so the next acceptance is possible then.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - An access with `addr` not size-aligned (h: bit0; w: bits1:0; d: bits2:0) issues no bus transaction.
  - It goes IDLE→DONE with `lsu_err=1`.
  - For a trapped load, `lsu_r_data` = 0.
- Undefined: the low address bits are used as-is for shift/strobe. Accesses that cross the 8-byte lane are truncated to the in-lane bytes. `lsu_err` reflects bus resp only.

## Test plan
- **lb sign-extension:** lb, addr 0x80000003, bus_r_data 0x00000000_80000000 → `lsu_r_data` 0xFFFFFFFFFFFFFF80 at cycle 3, `lsu_r_valid` one cycle, `lsu_err` 0.
- **sh strobes:** sh, addr 0x80000006, w_data 0xBEEF → `bus_w_strb` 0xC0, `bus_w_data` 0xBEEF000000000000, `bus_aw_addr` 0x80000000. AW ready delayed 3 cycles, W immediate → single `lsu_w_ready` after B.
- **Bus error:** lwu, addr 0x80000004, `bus_r_resp` 2, data 0xFFFFFFFF00000000 → `lsu_r_data` 0x00000000FFFFFFFF, `lsu_err` 1.
- **Misaligned, macro on/off:** lw at 0x80000002. With `LSU_MISALIGN_TRAP_EN`: no `bus_ar_valid`, `lsu_err` at cycle 1. Without: AR to 0x80000000, data shifted by 16.
- **Reset mid-access:** `rst`=0 while in R with `bus_r_valid` stalled → next cycle `idle`=1, all valids 0, no completion pulse. A new ld is then accepted normally.
- **Busy and invalid requests:** `in_valid` with `in_load=in_store=0` → no state change. A second request while `idle`=0 is ignored until after DONE.
